memc_dma_port_responder: RTL and testbench

Memory-controller-side responder for one streaming-ops lane DMA port. It terminates the `dma__memc__*` / `memc__dma__*` interface that each lane's `dma_cont` drives, services writes and reads against a single-port SRAM, and returns read data in order. Read data is buffered so that `dma__memc__read_pause` never loses data. One instance sits per PE/lane inside the memory controller.

---
 rtl/memc_dma_pkg.sv | 14 +
 rtl/memc_sram_1p.sv | 70 +++++++
 rtl/memc_dma_port_responder.sv | 129 ++++++++++++
 tb/tb_memc_dma_port_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memc_dma_pkg.sv
// Shared types and default widths for the memory-controller DMA port responder.
package memc_dma_pkg;

  localparam int MEMC_DMA_DATA_WIDTH     = 32;
  localparam int MEMC_DMA_ADDR_WIDTH     = 24;
  localparam int MEMC_DMA_MEM_DEPTH_LOG2 = 10;
  localparam int MEMC_DMA_RD_LATENCY     = 2;
  localparam int MEMC_DMA_RD_FIFO_DEPTH  = 4;
  localparam int MEMC_DMA_WR_BURST_MAX   = 4;

  typedef logic [MEMC_DMA_ADDR_WIDTH-1:0] memc_dma_addr_t;
  typedef logic [MEMC_DMA_DATA_WIDTH-1:0] memc_dma_data_t;

endpackage

// File: rtl/memc_sram_1p.sv
// Behavioral single-port SRAM. A read issued in cycle N shows up on rdata/rvalid
// RD_LATENCY cycles later; RD_LATENCY == 0 gives an asynchronous read.
// rvalid is a reset-cleared shift register so reads in flight can be discarded.
module memc_sram_1p
  import memc_dma_pkg::*;
#(
  parameter int DATA_WIDTH = MEMC_DMA_DATA_WIDTH,
  parameter int DEPTH_LOG2 = MEMC_DMA_MEM_DEPTH_LOG2,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic                  rd_en;

  assign rd_en = en && !we;

  // Write port: the array is updated at the end of the accepting cycle.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_async
      logic unused_srst;
      assign unused_srst = srst;
      assign rdata       = mem[addr];
      assign rvalid      = rd_en;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_pipe_reg [RD_LATENCY];
      logic [RD_LATENCY-1:0] valid_pipe_reg;

      // Registered array read followed by plain delay stages; no reset on data.
      always_ff @(posedge clk) begin
        if (rd_en) begin
          data_pipe_reg[0] <= mem[addr];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
          data_pipe_reg[i] <= data_pipe_reg[i-1];
        end
      end

      // Valid tags travel alongside the data; reset drops every read in flight.
      always_ff @(posedge clk) begin
        if (srst) begin
          valid_pipe_reg <= '0;
        end else begin
          valid_pipe_reg[0] <= rd_en;
          for (int i = 1; i < RD_LATENCY; i++) begin
            valid_pipe_reg[i] <= valid_pipe_reg[i-1];
          end
        end
      end

      assign rdata  = data_pipe_reg[RD_LATENCY-1];
      assign rvalid = valid_pipe_reg[RD_LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/memc_dma_port_responder.sv
// Memory-controller responder for one lane's DMA port: arbitrates a single SRAM
// port between writes and reads, bounds write bursts while a read waits, and
// returns read data in order through a credit-managed FIFO so pause never drops data.
module memc_dma_port_responder
  import memc_dma_pkg::*;
#(
  parameter int DATA_WIDTH     = MEMC_DMA_DATA_WIDTH,
  parameter int ADDR_WIDTH     = MEMC_DMA_ADDR_WIDTH,
  parameter int MEM_DEPTH_LOG2 = MEMC_DMA_MEM_DEPTH_LOG2,
  parameter int RD_LATENCY     = MEMC_DMA_RD_LATENCY,
  parameter int RD_FIFO_DEPTH  = MEMC_DMA_RD_FIFO_DEPTH,
  parameter int WR_BURST_MAX   = MEMC_DMA_WR_BURST_MAX
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  dma__memc__write_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__write_address,
  input  logic [DATA_WIDTH-1:0] dma__memc__write_data,
  output logic                  memc__dma__write_ready,
  input  logic                  dma__memc__read_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__read_address,
  output logic                  memc__dma__read_ready,
  input  logic                  dma__memc__read_pause,
  output logic [DATA_WIDTH-1:0] memc__dma__read_data,
  output logic                  memc__dma__read_data_valid
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);
  localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int RUN_W = $clog2(WR_BURST_MAX + 1);

  localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(RD_FIFO_DEPTH - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT    = RUN_W'(WR_BURST_MAX);
  localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(RD_FIFO_DEPTH);

  logic [RUN_W-1:0]      wr_run_reg;
  logic [CNT_W-1:0]      fifo_count_reg;
  logic [CNT_W-1:0]      inflight_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];

  logic                      write_grant;
  logic                      read_grant;
  logic                      credit_ok;
  logic [CNT_W:0]            occupancy;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [DATA_WIDTH-1:0]     push_data;
  logic [MEM_DEPTH_LOG2-1:0] sram_addr;
  logic                      unused_addr_bits;

  // Only the low address bits reach the SRAM, so addresses alias modulo its depth.
  assign unused_addr_bits = ^{dma__memc__write_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2],
                              dma__memc__read_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2]};

  // Writes win the port unless they have starved a waiting read for a full burst.
  assign memc__dma__write_ready = !reset_poweron && (wr_run_reg != RUN_LIMIT);
  assign write_grant            = dma__memc__write_valid && memc__dma__write_ready;

  // Every accepted read owns a FIFO slot from acceptance until it is popped.
  assign occupancy             = {1'b0, fifo_count_reg} + {1'b0, inflight_reg};
  assign credit_ok             = occupancy < CREDIT_LIMIT;
  assign memc__dma__read_ready = !reset_poweron && credit_ok && !write_grant;
  assign read_grant            = dma__memc__read_valid && memc__dma__read_ready;

  assign sram_addr = write_grant ? dma__memc__write_address[MEM_DEPTH_LOG2-1:0]
                                 : dma__memc__read_address[MEM_DEPTH_LOG2-1:0];

  // The FIFO write is the final registered stage of the read path, so the SRAM
  // contributes one cycle less than the end-to-end read latency.
  memc_sram_1p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2),
    .RD_LATENCY (RD_LATENCY - 1)
  ) u_sram (
    .clk    (clk),
    .srst   (reset_poweron),
    .en     (write_grant || read_grant),
    .we     (write_grant),
    .addr   (sram_addr),
    .wdata  (dma__memc__write_data),
    .rvalid (fifo_push),
    .rdata  (push_data)
  );

  // Pause gates the pop combinationally; the head stays put until it is taken.
  assign fifo_pop                   = !reset_poweron && (fifo_count_reg != '0) && !dma__memc__read_pause;
  assign memc__dma__read_data_valid = fifo_pop;
  assign memc__dma__read_data       = reset_poweron ? '0 : fifo_mem[rd_ptr_reg];

  // Burst counter: only consecutive writes while a read is waiting count.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_run_reg <= '0;
    end else if (read_grant || !dma__memc__read_valid) begin
      wr_run_reg <= '0;
    end else if (write_grant) begin
      wr_run_reg <= wr_run_reg + RUN_W'(1);
    end
  end

  // FIFO pointers, occupancy and in-flight read count.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      inflight_reg   <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      fifo_count_reg <= fifo_count_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      inflight_reg   <= inflight_reg + CNT_W'(read_grant) - CNT_W'(fifo_push);
    end
  end

  // FIFO storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: tb/tb_memc_dma_port_responder.sv
// Self-checking bench: randomized and directed traffic compared cycle by cycle
// against a timestamped-queue model of the responder's externally visible rules.
module tb_memc_dma_port_responder;
  import memc_dma_pkg::*;

  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int BURST = 4;

  logic           clk = 1'b0;
  logic           reset_poweron;
  logic           write_valid;
  memc_dma_addr_t write_address;
  memc_dma_data_t write_data;
  logic           write_ready;
  logic           read_valid;
  memc_dma_addr_t read_address;
  logic           read_ready;
  logic           read_pause;
  memc_dma_data_t read_data;
  logic           read_data_valid;

  always #5 clk = ~clk;

  memc_dma_port_responder dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .dma__memc__write_valid     (write_valid),
    .dma__memc__write_address   (write_address),
    .dma__memc__write_data      (write_data),
    .memc__dma__write_ready     (write_ready),
    .dma__memc__read_valid      (read_valid),
    .dma__memc__read_address    (read_address),
    .memc__dma__read_ready      (read_ready),
    .dma__memc__read_pause      (read_pause),
    .memc__dma__read_data       (read_data),
    .memc__dma__read_data_valid (read_data_valid)
  );

  typedef struct {
    logic [31:0] d;
    int          t;
  } rd_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  rd_t         exp_q[$];
  logic [31:0] mem_m [1024];
  int          run_m = 0;
  logic [34:0] exp_vec;
  logic [34:0] obs_vec;
  bit          obs_wg;
  bit          obs_rg;

  // One clock of stimulus; reference model computes expectations for this cycle.
  task automatic step(input bit rst, input bit wv, input memc_dma_addr_t wa,
                      input memc_dma_data_t wd, input bit rv,
                      input memc_dma_addr_t ra, input bit ps);
    bit e_wr, e_rr, e_rdv, e_care, e_wg, e_rg, head_ready;
    logic [31:0] e_d;
    rd_t ent;
    reset_poweron = rst;
    write_valid   = wv;
    write_address = wa;
    write_data    = wd;
    read_valid    = rv;
    read_address  = ra;
    read_pause    = ps;
    @(negedge clk);
    if (rst) begin
      e_wr = 0; e_rr = 0; e_rdv = 0; e_care = 1; e_d = '0;
      exp_q.delete();
      run_m = 0;
    end else begin
      e_wr       = run_m < BURST;
      e_wg       = wv && e_wr;
      e_rr       = (exp_q.size() < DEPTH) && !e_wg;
      e_rg       = rv && e_rr;
      head_ready = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
      e_rdv      = head_ready && !ps;
      e_care     = head_ready;
      e_d        = head_ready ? exp_q[0].d : '0;
      if (e_rdv) void'(exp_q.pop_front());
      if (e_rg) begin
        ent.d = mem_m[ra[9:0]];
        ent.t = cyc + L;
        exp_q.push_back(ent);
      end
      if (e_wg) mem_m[wa[9:0]] = wd;
      if (e_rg || !rv) run_m = 0;
      else if (e_wg) run_m++;
    end
    exp_vec = {e_wr, e_rr, e_rdv, e_d};
    obs_vec = {write_ready, read_ready, read_data_valid, e_care ? read_data : 32'h0};
    obs_wg  = wv && write_ready;
    obs_rg  = rv && read_ready;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 24'h5, 32'h1, 1, 24'h5, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL reset c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL reset_release c%0d: got %h need %h", cyc, obs_vec, exp_vec);
    end
  endtask

  task automatic test_write_then_read();
    int rd_cyc;
    int got_cyc;
    logic [31:0] got_d;
    got_cyc = -1;
    got_d   = '0;
    step(0, 1, 24'h10, 32'hDEADBEEF, 0, 0, 0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL wtr_write c%0d: got %h need %h", cyc, obs_vec, exp_vec);
    end
    rd_cyc = cyc;
    step(0, 0, 0, 0, 1, 24'h10, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL wtr c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
      if (obs_vec[32] === 1'b1 && got_cyc < 0) begin
        got_cyc = cyc - 1;
        got_d   = obs_vec[31:0];
      end
    end
    n_cmp++;
    if (got_cyc != rd_cyc + 2 || got_d !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wtr_latency: got cycle %0d data %h need cycle %0d data deadbeef",
               got_cyc, got_d, rd_cyc + 2);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int first;
    int last;
    k = 0; first = -1; last = -1;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, memc_dma_addr_t'(i), 32'(i * 3), 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL b2b_preload c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, (i < 8), memc_dma_addr_t'(i), 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL b2b c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
      if (obs_vec[32] === 1'b1) begin
        n_cmp++;
        if (obs_vec[31:0] !== 32'(k * 3)) begin
          n_err++;
          $display("FAIL b2b_data #%0d: got %h need %h", k, obs_vec[31:0], 32'(k * 3));
        end
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
    end
    n_cmp++;
    if (k != 8 || last - first != 7) begin
      n_err++;
      $display("FAIL b2b_stream: got %0d beats over %0d cycles need 8 over 8", k, last - first + 1);
    end
  endtask

  task automatic test_pause();
    int granted;
    int beats;
    granted = 0; beats = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1, memc_dma_addr_t'(i % 8), 1);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL pause c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
      if (obs_rg) granted++;
    end
    n_cmp++;
    if (granted != DEPTH) begin
      n_err++;
      $display("FAIL pause_credit: got %0d grants need %0d", granted, DEPTH);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL pause_drain c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
      if (obs_vec[32] === 1'b1) beats++;
    end
    n_cmp++;
    if (beats != DEPTH) begin
      n_err++;
      $display("FAIL pause_beats: got %0d need %0d", beats, DEPTH);
    end
  endtask

  task automatic test_contention();
    int nw;
    int nr;
    nw = 0; nr = 0;
    for (int i = 0; i < 25; i++) begin
      step(0, 1, memc_dma_addr_t'(24'h200 + i), $urandom, 1, memc_dma_addr_t'(i % 8), 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL contention c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
      n_cmp++;
      if (obs_rg !== (i % 5 == 4) || obs_wg !== (i % 5 != 4)) begin
        n_err++;
        $display("FAIL contention_grant slot%0d: got w%0d r%0d need w%0d r%0d",
                 i, obs_wg, obs_rg, (i % 5 != 4), (i % 5 == 4));
      end
      if (obs_wg) nw++;
      if (obs_rg) nr++;
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL contention_drain c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (nw != 20 || nr != 5) begin
      n_err++;
      $display("FAIL contention_totals: got %0d w %0d r need 20 w 5 r", nw, nr);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] d;
    logic [31:0] got;
    bit seen;
    d = $urandom; seen = 0; got = '0;
    step(0, 1, 24'h000400, d, 0, 0, 0);
    step(0, 0, 0, 0, 1, 24'h000000, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL wrap c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
      if (obs_vec[32] === 1'b1) begin
        seen = 1;
        got  = obs_vec[31:0];
      end
    end
    n_cmp++;
    if (!seen || got !== d) begin
      n_err++;
      $display("FAIL wrap_data: got seen=%0d %h need %h", seen, got, d);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    logic [31:0] got;
    stale = 0; got = '0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, memc_dma_addr_t'(i), 0);
    step(1, 1, 24'h3, 32'h0, 1, 24'h3, 0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL rstmid_outputs c%0d: got %h need %h", cyc, obs_vec, exp_vec);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (obs_vec[32] !== 1'b0) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_err++;
      $display("FAIL rstmid_stale: got %0d valid beats need 0", stale);
    end
    step(0, 0, 0, 0, 1, 24'h5, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL rstmid_fresh c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
      if (obs_vec[32] === 1'b1) got = obs_vec[31:0];
    end
    n_cmp++;
    if (got !== 32'd15) begin
      n_err++;
      $display("FAIL rstmid_fresh_data: got %h need 0000000f", got);
    end
  endtask

  task automatic test_random();
    memc_dma_addr_t wa;
    memc_dma_addr_t ra;
    for (int k = 0; k < 16; k++) begin
      wa = memc_dma_addr_t'($urandom);
      wa[9:0] = 10'h100 + 10'(k);
      step(0, 1, wa, $urandom, 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random_preload c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 400; i++) begin
      wa = memc_dma_addr_t'($urandom);
      wa[9:0] = 10'h100 + 10'($urandom_range(0, 15));
      ra = memc_dma_addr_t'($urandom);
      ra[9:0] = 10'h100 + 10'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), wa, $urandom,
           ($urandom_range(0, 2) != 0), ra, ($urandom_range(0, 3) == 0));
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random_drain c%0d: got %h need %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    reset_poweron = 1'b1;
    write_valid   = 1'b0;
    write_address = '0;
    write_data    = '0;
    read_valid    = 1'b0;
    read_address  = '0;
    read_pause    = 1'b0;
    test_reset();
    test_write_then_read();
    test_back_to_back();
    test_pause();
    test_contention();
    test_addr_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
